// File: rtl/imem_load_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_if
// Brief    : Request, status and imem write-port bundle for imem_load_ctrl.
//            load_csum exists only when LOAD_CSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_load_if #(
    parameter int ADDR_WIDTH = 14
);
    // front-panel requester
    logic                  panel_deposit;
    logic                  panel_deposit_nxt;
    logic [ADDR_WIDTH-1:0] panel_addr;
    logic [15:0]           panel_data;
    logic                  panel_err;

    // serial bootloader requester
    logic                  ser_start;
    logic [ADDR_WIDTH-1:0] ser_base;
    logic [ADDR_WIDTH:0]   ser_len;
    logic                  ser_abort;
    logic                  ser_valid;
    logic [7:0]            ser_byte;
    logic                  ser_ready;

    // imem write port and status
    logic                  altair_we;
    logic [ADDR_WIDTH-1:0] altair_waddr;
    logic [15:0]           altair_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   words_loaded;
`ifdef LOAD_CSUM_EN
    logic [15:0]           load_csum;
`endif

    // master: requesters and consumers of the write port
    modport master (
        output panel_deposit, panel_deposit_nxt, panel_addr, panel_data,
        output ser_start, ser_base, ser_len, ser_abort, ser_valid, ser_byte,
        input  panel_err, ser_ready,
        input  altair_we, altair_waddr, altair_wdata,
        input  cpu_hold, busy, done, words_loaded
`ifdef LOAD_CSUM_EN
        , input load_csum
`endif
    );

    // slave: the load controller
    modport slave (
        input  panel_deposit, panel_deposit_nxt, panel_addr, panel_data,
        input  ser_start, ser_base, ser_len, ser_abort, ser_valid, ser_byte,
        output panel_err, ser_ready,
        output altair_we, altair_waddr, altair_wdata,
        output cpu_hold, busy, done, words_loaded
`ifdef LOAD_CSUM_EN
        , output load_csum
`endif
    );
endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Brief    : Arbitrates front-panel deposits and a serial byte-stream loader
//            onto the imem write port; holds the CPU while a load runs.
//            Optional LOAD_CSUM_EN adds a per-session 16-bit word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic       clk,
    input  logic       rst,
    imem_load_if.slave bus
);

    localparam int c_LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PANEL_WR = 3'd1,
        SER_LO   = 3'd2,
        SER_HI   = 3'd3,
        SER_WR   = 3'd4,
        SER_DONE = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [c_LEN_W-1:0]    r_len;
    logic [c_LEN_W-1:0]    r_words;
    logic [7:0]            r_lo;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [15:0]           r_wdata;
    logic                  r_pend;
    logic                  r_panel_err;

    logic                  w_panel_req;
    logic [ADDR_WIDTH-1:0] w_panel_tgt;
    logic                  w_panel_go;
    logic                  w_start_latch;
    logic                  w_byte_lo;
    logic                  w_byte_hi;
    logic                  w_ser_wr;
    logic                  w_last_word;

    assign w_panel_req = bus.panel_deposit | bus.panel_deposit_nxt;
    // a direct deposit takes priority over deposit-next when both pulse together
    assign w_panel_tgt = bus.panel_deposit ? bus.panel_addr
                                           : r_last_addr + ADDR_WIDTH'(1);
    assign w_last_word = ((r_words + c_LEN_W'(1)) == r_len);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_panel_go    = 1'b0;
        w_start_latch = 1'b0;
        w_byte_lo     = 1'b0;
        w_byte_hi     = 1'b0;
        w_ser_wr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_latch = bus.ser_start;
                if (w_panel_req) begin
                    w_panel_go  = 1'b1;
                    w_state_nxt = PANEL_WR;
                end else if (bus.ser_start) begin
                    w_state_nxt = (bus.ser_len == '0) ? SER_DONE : SER_LO;
                end
            end
            PANEL_WR: begin
                // a start that arrived with the deposit was latched and runs now
                if (r_pend) begin
                    w_state_nxt = (r_len == '0) ? SER_DONE : SER_LO;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SER_LO: begin
                if (bus.ser_abort) begin
                    w_state_nxt = IDLE;
                end else if (bus.ser_valid) begin
                    w_byte_lo   = 1'b1;
                    w_state_nxt = SER_HI;
                end
            end
            SER_HI: begin
                if (bus.ser_abort) begin
                    w_state_nxt = IDLE;
                end else if (bus.ser_valid) begin
                    w_byte_hi   = 1'b1;
                    w_state_nxt = SER_WR;
                end
            end
            SER_WR: begin
                w_ser_wr = 1'b1;
                if (bus.ser_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last_word) begin
                    w_state_nxt = SER_DONE;
                end else begin
                    w_state_nxt = SER_LO;
                end
            end
            SER_DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_addr <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_words     <= '0;
            r_lo        <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_pend      <= 1'b0;
            r_panel_err <= 1'b0;
        end else begin
            // any pulse outside IDLE is dropped and flagged
            r_panel_err <= w_panel_req && (r_state != IDLE);
            r_pend      <= w_start_latch && w_panel_go;

            if (w_panel_go) begin
                r_waddr     <= w_panel_tgt;
                r_wdata     <= bus.panel_data;
                r_last_addr <= w_panel_tgt;
            end

            if (w_start_latch) begin
                r_base  <= bus.ser_base;
                r_len   <= bus.ser_len;
                r_words <= '0;
            end

            if (w_byte_lo) begin
                r_lo <= bus.ser_byte;
            end

            // address and data are set up here so they are stable in SER_WR
            if (w_byte_hi) begin
                r_waddr <= r_base + r_words[ADDR_WIDTH-1:0];
                r_wdata <= {bus.ser_byte, r_lo};
            end

            if (w_ser_wr) begin
                r_words <= r_words + c_LEN_W'(1);
            end
        end
    end

`ifdef LOAD_CSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_start_latch) begin
            r_csum <= '0;
        end else if (w_ser_wr) begin
            r_csum <= r_csum + r_wdata;
        end
    end

    assign bus.load_csum = r_csum;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.altair_we    = (r_state == PANEL_WR) || (r_state == SER_WR);
    assign bus.altair_waddr = r_waddr;
    assign bus.altair_wdata = r_wdata;
    assign bus.ser_ready    = (r_state == SER_LO) || (r_state == SER_HI);
    assign bus.cpu_hold     = (r_state != IDLE);
    assign bus.busy         = (r_state == SER_LO) || (r_state == SER_HI) ||
                              (r_state == SER_WR) || (r_state == SER_DONE);
    assign bus.done         = (r_state == SER_DONE);
    assign bus.panel_err    = r_panel_err;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire
